tlb_maint_ctrl: RTL

Sequencer for the CP0 TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR). It sits directly upstream of the array of TLB header entries. It drives their write strobes and write data (PageMask, VPN2, G, ASID) and the probe key, then consumes their per-entry probe-match lines. It also owns the CP0 Random counter and returns probe/read results to CP0 with a done pulse.

---
 rtl/tlb_pkg.sv | 21 ++
 rtl/tlb_match_enc.sv | 31 +++
 rtl/tlb_maint_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared op codes, field widths and FSM encoding for the TLB maintenance sequencer
package tlb_pkg;

    localparam int VPN2_W  = 19;
    localparam int ASID_W  = 8;
    localparam int PMASK_W = 16;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } op_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } tlb_state_t;

endpackage

// File: rtl/tlb_match_enc.sv
// rtl/tlb_match_enc.sv - lowest-index priority encoder with any/multiple hit flags
// Ports:
//   match : per-entry probe match lines
//   idx   : lowest matching index (0 when nothing matches)
//   any   : at least one entry matches
//   multi : more than one entry matches
module tlb_match_enc #(
    parameter int ENTRIES = 16,
    parameter int IDXW    = 4
) (
    input  logic [ENTRIES-1:0] match,
    output logic [IDXW-1:0]    idx,
    output logic               any,
    output logic               multi
);

    // Scan downward so the lowest set bit wins the last assignment.
    always_comb begin
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    assign any   = |match;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(match & (match - ENTRIES'(1)));

endmodule

// File: rtl/tlb_maint_ctrl.sv
// rtl/tlb_maint_ctrl.sv - CP0 TLBP/TLBR/TLBWI/TLBWR sequencer with Random counter
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   op_valid/op_ready/op_code          : request handshake and opcode
//   ehi_vpn2, ehi_asid, pagemask       : EntryHi / PageMask operands
//   lo0_g, lo1_g, index_in             : EntryLo G bits, CP0 Index
//   wired_in, wired_we                 : CP0 Wired value and write strobe
//   hdr_we, hdr_pagemask/vpn2/g/asid   : header entry write strobe and data
//   probe_vpn2, probe_asid, probe_match: probe key out, per-entry match in
//   rd_idx, rd_pagemask/vpn2/g/asid    : read select out, selected header in
//   done, res_*                        : completion pulse and TLBP/TLBR results
//   random                             : CP0 Random
module tlb_maint_ctrl
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDXW    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [1:0]          op_code,
    input  logic [VPN2_W-1:0]   ehi_vpn2,
    input  logic [ASID_W-1:0]   ehi_asid,
    input  logic [PMASK_W-1:0]  pagemask,
    input  logic                lo0_g,
    input  logic                lo1_g,
    input  logic [IDXW-1:0]     index_in,
    input  logic [IDXW-1:0]     wired_in,
    input  logic                wired_we,
    output logic [ENTRIES-1:0]  hdr_we,
    output logic [PMASK_W-1:0]  hdr_pagemask,
    output logic [VPN2_W-1:0]   hdr_vpn2,
    output logic                hdr_g,
    output logic [ASID_W-1:0]   hdr_asid,
    output logic [VPN2_W-1:0]   probe_vpn2,
    output logic [ASID_W-1:0]   probe_asid,
    input  logic [ENTRIES-1:0]  probe_match,
    output logic [IDXW-1:0]     rd_idx,
    input  logic [PMASK_W-1:0]  rd_pagemask,
    input  logic [VPN2_W-1:0]   rd_vpn2,
    input  logic                rd_g,
    input  logic [ASID_W-1:0]   rd_asid,
    output logic                done,
    output logic [IDXW-1:0]     res_index,
    output logic                res_miss,
    output logic                res_multi,
    output logic [PMASK_W-1:0]  res_pagemask,
    output logic [VPN2_W-1:0]   res_vpn2,
    output logic                res_g,
    output logic [ASID_W-1:0]   res_asid,
    output logic [IDXW-1:0]     random
);

    localparam logic [IDXW-1:0] RND_MAX = IDXW'(ENTRIES - 1);

    tlb_state_t          state;
    tlb_state_t          state_nxt;
    op_code_t            op_q;
    logic [VPN2_W-1:0]   vpn2_q;
    logic [ASID_W-1:0]   asid_q;
    logic [PMASK_W-1:0]  pm_q;
    logic                g_q;
    logic [IDXW-1:0]     tgt_q;
    logic                accept;
    logic                exec_probe;
    logic                exec_read;

    logic [IDXW-1:0]     enc_idx;
    logic                enc_any;
    logic                enc_multi;

    tlb_match_enc #(
        .ENTRIES (ENTRIES),
        .IDXW    (IDXW)
    ) u_match_enc (
        .match (probe_match),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // hdr_we is decoded from the state register so an asynchronous reset
    // removes the strobe in the same instant, before any partial write.
    always_comb begin
        state_nxt  = state;
        op_ready   = 1'b0;
        done       = 1'b0;
        hdr_we     = '0;
        exec_probe = 1'b0;
        exec_read  = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                accept   = op_valid;
                if (op_valid) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt  = ST_DONE;
                exec_probe = (op_q == OP_TLBP);
                exec_read  = (op_q == OP_TLBR);
                if (op_q == OP_TLBWI || op_q == OP_TLBWR) begin
                    // An out-of-range target simply matches no entry.
                    for (int i = 0; i < ENTRIES; i++) begin
                        if (tgt_q == IDXW'(i)) begin
                            hdr_we[i] = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                done      = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_TLBP;
            vpn2_q <= '0;
            asid_q <= '0;
            pm_q   <= '0;
            g_q    <= 1'b0;
            tgt_q  <= '0;
        end else if (accept) begin
            op_q   <= op_code_t'(op_code);
            vpn2_q <= ehi_vpn2;
            asid_q <= ehi_asid;
            pm_q   <= pagemask;
            g_q    <= lo0_g & lo1_g;
            tgt_q  <= (op_code == OP_TLBWR) ? random : index_in;
        end
    end

    assign hdr_pagemask = pm_q;
    assign hdr_vpn2     = vpn2_q;
    assign hdr_g        = g_q;
    assign hdr_asid     = asid_q;
    assign probe_vpn2   = vpn2_q;
    assign probe_asid   = asid_q;
    assign rd_idx       = tgt_q;

    // Results are sampled on the EXEC->DONE edge; each op refreshes only its
    // own result group, everything else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_index    <= '0;
            res_miss     <= 1'b0;
            res_multi    <= 1'b0;
            res_pagemask <= '0;
            res_vpn2     <= '0;
            res_g        <= 1'b0;
            res_asid     <= '0;
        end else begin
            if (exec_probe) begin
                res_index <= enc_idx;
                res_miss  <= ~enc_any;
                res_multi <= enc_multi;
            end
            if (exec_read) begin
                res_pagemask <= rd_pagemask;
                res_vpn2     <= rd_vpn2;
                res_g        <= rd_g;
                res_asid     <= rd_asid;
            end
        end
    end

    // Wrap covers wired_in >= ENTRIES-1 too: random can never exceed it,
    // so it is pinned at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random <= RND_MAX;
        end else if (wired_we || random <= wired_in) begin
            random <= RND_MAX;
        end else begin
            random <= random - IDXW'(1);
        end
    end

endmodule
